// File: rtl/gpio_debounce_ctrl.sv
// Multi-pin GPIO debouncer: synchroniser, per-pin stability counter, edge pulses.
// Define GPIO_DEBOUNCE_IRQ_EN to build the sticky, maskable interrupt logic.
module gpio_debounce_ctrl #(
    parameter int NUM_PINS    = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RESET_LEVEL = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_PINS-1:0] gpio_in,
    input  logic                cfg_enable,
    input  logic [CNT_W-1:0]    cfg_threshold,
    input  logic [NUM_PINS-1:0] cfg_bypass,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] rise_pulse,
    output logic [NUM_PINS-1:0] fall_pulse,
    input  logic [NUM_PINS-1:0] irq_rise_mask,
    input  logic [NUM_PINS-1:0] irq_fall_mask,
    input  logic [NUM_PINS-1:0] irq_clear,
    output logic [NUM_PINS-1:0] irq_status,
    output logic                irq
);

    localparam logic [NUM_PINS-1:0] RST_VEC = (RESET_LEVEL != 0) ? {NUM_PINS{1'b1}} : '0;

    // Last count value before a switch; a threshold of 0 behaves like 1.
    function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] thr);
        return (thr == '0) ? '0 : thr - CNT_W'(1);
    endfunction

    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync_s;
    logic [CNT_W-1:0]    cnt_q   [NUM_PINS];
    logic [CNT_W-1:0]    cnt_nxt [NUM_PINS];
    logic [NUM_PINS-1:0] out_nxt;
    logic [NUM_PINS-1:0] rise_nxt;
    logic [NUM_PINS-1:0] fall_nxt;
    logic [CNT_W-1:0]    thr_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RST_VEC;
        end else begin
            sync_q[0] <= gpio_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign thr_last = last_count(cfg_threshold);

    always_comb begin
        out_nxt  = gpio_out;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            cnt_nxt[i] = '0;
            if (cfg_enable) begin
                if (cfg_bypass[i]) begin
                    out_nxt[i]  = sync_s[i];
                    rise_nxt[i] = sync_s[i] & ~gpio_out[i];
                    fall_nxt[i] = ~sync_s[i] & gpio_out[i];
                end else if (sync_s[i] != gpio_out[i]) begin
                    // Saturates at thr_last, so a lowered threshold switches at once.
                    if (cnt_q[i] >= thr_last) begin
                        out_nxt[i]  = sync_s[i];
                        rise_nxt[i] = sync_s[i];
                        fall_nxt[i] = ~sync_s[i];
                    end else begin
                        cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_out   <= RST_VEC;
            rise_pulse <= '0;
            fall_pulse <= '0;
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
        end else begin
            gpio_out   <= out_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= cnt_nxt[i];
        end
    end

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [NUM_PINS-1:0] irq_set;

    assign irq_set = (rise_pulse & irq_rise_mask) | (fall_pulse & irq_fall_mask);

    // A new event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~irq_clear) | irq_set;
            irq        <= |irq_status;
        end
    end
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{irq_rise_mask, irq_fall_mask, irq_clear};
    assign irq_status        = '0;
    assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_debounce_ctrl.sv
// Self-checking bench for gpio_debounce_ctrl: cycle model feeding a scoreboard queue
// plus directed checks of latency, glitch rejection, bypass, enable and interrupts.
module tb_gpio_debounce_ctrl;

    localparam int NUM_PINS = 16;
    localparam int CNT_W    = 16;
    localparam int SYNC     = 2;
`ifdef GPIO_DEBOUNCE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    typedef struct packed {
        logic [NUM_PINS-1:0] out;
        logic [NUM_PINS-1:0] rise;
        logic [NUM_PINS-1:0] fall;
        logic [NUM_PINS-1:0] stat;
        logic                irq;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NUM_PINS-1:0] gpio_in;
    logic                cfg_enable;
    logic [CNT_W-1:0]    cfg_threshold;
    logic [NUM_PINS-1:0] cfg_bypass;
    logic [NUM_PINS-1:0] gpio_out;
    logic [NUM_PINS-1:0] rise_pulse;
    logic [NUM_PINS-1:0] fall_pulse;
    logic [NUM_PINS-1:0] irq_rise_mask;
    logic [NUM_PINS-1:0] irq_fall_mask;
    logic [NUM_PINS-1:0] irq_clear;
    logic [NUM_PINS-1:0] irq_status;
    logic                irq;

    int n_checks = 0;
    int n_errors = 0;

    exp_t                sb[$];
    logic [NUM_PINS-1:0] m_sync [SYNC];
    logic [NUM_PINS-1:0] m_out  = '0;
    logic [NUM_PINS-1:0] m_rise = '0;
    logic [NUM_PINS-1:0] m_fall = '0;
    logic [NUM_PINS-1:0] m_stat = '0;
    logic                m_irq  = 1'b0;
    int                  m_cnt [NUM_PINS];
    logic [NUM_PINS-1:0] rise_acc = '0;
    logic [NUM_PINS-1:0] fall_acc = '0;

    always #5 clk = ~clk;

    gpio_debounce_ctrl #(
        .NUM_PINS(NUM_PINS), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .RESET_LEVEL(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .gpio_in(gpio_in), .cfg_enable(cfg_enable),
        .cfg_threshold(cfg_threshold), .cfg_bypass(cfg_bypass), .gpio_out(gpio_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .irq_rise_mask(irq_rise_mask),
        .irq_fall_mask(irq_fall_mask), .irq_clear(irq_clear), .irq_status(irq_status),
        .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Predicts the outputs after the coming clock edge from the inputs now applied.
    task automatic model_step();
        logic [NUM_PINS-1:0] s;
        logic [NUM_PINS-1:0] n_out;
        logic [NUM_PINS-1:0] n_stat;
        logic                n_irq;
        int                  thr;
        thr   = (cfg_threshold == 0) ? 1 : int'(cfg_threshold);
        s     = m_sync[SYNC-1];
        n_out = m_out;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (!cfg_enable) begin
                m_cnt[i] = 0;
            end else if (cfg_bypass[i]) begin
                n_out[i] = s[i];
                m_cnt[i] = 0;
            end else if (s[i] == m_out[i]) begin
                m_cnt[i] = 0;
            end else if (m_cnt[i] + 1 >= thr) begin
                n_out[i] = s[i];
                m_cnt[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        n_stat = IRQ_ON ? ((m_stat & ~irq_clear) | (m_rise & irq_rise_mask) |
                           (m_fall & irq_fall_mask)) : '0;
        n_irq  = IRQ_ON ? (|m_stat) : 1'b0;
        m_rise = n_out & ~m_out;
        m_fall = m_out & ~n_out;
        m_out  = n_out;
        m_stat = n_stat;
        m_irq  = n_irq;
        for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = gpio_in;
        sb.push_back('{m_out, m_rise, m_fall, m_stat, m_irq});
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_gpio_out",   32'(gpio_out),   32'(e.out));
        check("sb_rise_pulse", 32'(rise_pulse), 32'(e.rise));
        check("sb_fall_pulse", 32'(fall_pulse), 32'(e.fall));
        check("sb_irq_status", 32'(irq_status), 32'(e.stat));
        check("sb_irq",        32'(irq),        32'(e.irq));
        rise_acc = rise_acc | rise_pulse;
        fall_acc = fall_acc | fall_pulse;
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
        for (int i = 0; i < NUM_PINS; i++) m_cnt[i] = 0;
        reset_n       = 1'b0;
        gpio_in       = '1;
        cfg_enable    = 1'b1;
        cfg_threshold = 16'd4;
        cfg_bypass    = '0;
        irq_rise_mask = '0;
        irq_fall_mask = '0;
        irq_clear     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gpio_out", 32'(gpio_out),   32'h0);
        check("rst_rise",     32'(rise_pulse), 32'h0);
        check("rst_fall",     32'(fall_pulse), 32'h0);
        check("rst_status",   32'(irq_status), 32'h0);
        check("rst_irq",      32'(irq),        32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Step from reset: all pins rise SYNC+4 cycles after release.
        repeat (SYNC + 3) tick();
        check("t1_before", 32'(gpio_out), 32'h0);
        tick();
        check("t1_out",  32'(gpio_out),   32'hFFFF);
        check("t1_rise", 32'(rise_pulse), 32'hFFFF);
        tick();
        check("t1_rise_once", 32'(rise_pulse), 32'h0);
        gpio_in = '0;
        repeat (12) tick();
        check("t1_low", 32'(gpio_out), 32'h0);

        // 9-cycle glitch rejected at thr=10; 10-cycle level accepted.
        cfg_threshold = 16'd10;
        rise_acc = '0;
        gpio_in[3] = 1'b1;
        repeat (9) tick();
        gpio_in[3] = 1'b0;
        repeat (15) tick();
        check("t2_glitch_out",  32'(gpio_out[3]), 32'h0);
        check("t2_glitch_rise", 32'(rise_acc[3]), 32'h0);
        gpio_in[3] = 1'b1;
        repeat (10) tick();
        gpio_in[3] = 1'b0;
        tick();
        check("t2_pre_switch", 32'(gpio_out[3]), 32'h0);
        tick();
        check("t2_switch", 32'(gpio_out[3]),   32'h1);
        check("t2_rise",   32'(rise_pulse[3]), 32'h1);
        repeat (15) tick();
        check("t2_back_low", 32'(gpio_out[3]), 32'h0);

        // Threshold 0 acts as 1; maximum threshold ignores a single-cycle pulse.
        cfg_threshold = 16'd0;
        gpio_in[7] = 1'b1;
        repeat (SYNC) tick();
        check("t3_thr0_wait", 32'(gpio_out[7]), 32'h0);
        tick();
        check("t3_thr0_rise", 32'(gpio_out[7]), 32'h1);
        gpio_in[7] = 1'b0;
        repeat (SYNC + 1) tick();
        check("t3_thr0_fall", 32'(gpio_out[7]), 32'h0);
        cfg_threshold = 16'hFFFF;
        rise_acc = '0;
        gpio_in[8] = 1'b1;
        tick();
        gpio_in[8] = 1'b0;
        repeat (10) tick();
        check("t3_max_out",  32'(gpio_out[8]), 32'h0);
        check("t3_max_rise", 32'(rise_acc[8]), 32'h0);

        // Threshold lowered mid-count (cnt=20) switches on the next cycle.
        cfg_threshold = 16'd100;
        gpio_in[0] = 1'b1;
        repeat (22) tick();
        check("t4_counting", 32'(gpio_out[0]), 32'h0);
        cfg_threshold = 16'd8;
        tick();
        check("t4_thr_drop",      32'(gpio_out[0]),   32'h1);
        check("t4_thr_drop_rise", 32'(rise_pulse[0]), 32'h1);

        // Disabled: outputs frozen, bypass ignored, no pulses.
        cfg_enable = 1'b0;
        rise_acc = '0;
        fall_acc = '0;
        gpio_in[0] = 1'b0;
        cfg_bypass[5] = 1'b1;
        gpio_in[5] = 1'b1;
        repeat (15) tick();
        check("t4_frozen",     32'(gpio_out[0]), 32'h1);
        check("t4_no_bypass",  32'(gpio_out[5]), 32'h0);
        check("t4_no_rise",    32'(rise_acc),    32'h0);
        check("t4_no_fall",    32'(fall_acc),    32'h0);
        gpio_in = '0;
        cfg_bypass = '0;
        cfg_enable = 1'b1;
        cfg_threshold = 16'd4;
        repeat (20) tick();
        check("t4_settled", 32'(gpio_out), 32'h0);

        // Bypass: pin 5 mirrors a toggling input with pulses every change.
        cfg_bypass[5] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            gpio_in[5] = k[0];
            tick();
            if (k == SYNC + 1) check("t5_bypass_rise", 32'(rise_pulse[5]), 32'h1);
            if (k == SYNC + 2) check("t5_bypass_fall", 32'(fall_pulse[5]), 32'h1);
        end
        gpio_in[5] = 1'b0;
        repeat (4) tick();
        cfg_bypass = '0;
        repeat (8) tick();

        // Interrupts: rise sets status, clear alone clears, set beats clear.
        irq_rise_mask[2] = 1'b1;
        gpio_in[2] = 1'b1;
        repeat (SYNC + 4) tick();
        check("t6_rise", 32'(rise_pulse[2]), 32'h1);
        tick();
        check("t6_status_set", 32'(irq_status[2]), 32'(IRQ_ON));
        tick();
        check("t6_irq_set", 32'(irq), 32'(IRQ_ON));
        irq_clear[2] = 1'b1;
        tick();
        irq_clear = '0;
        check("t6_status_clr", 32'(irq_status[2]), 32'h0);
        tick();
        check("t6_irq_clr", 32'(irq), 32'h0);
        gpio_in[2] = 1'b0;
        repeat (10) tick();
        check("t6_fall_masked", 32'(irq_status[2]), 32'h0);
        gpio_in[2] = 1'b1;
        repeat (SYNC + 4) tick();
        irq_clear[2] = 1'b1;
        tick();
        irq_clear = '0;
        check("t6_set_wins", 32'(irq_status[2]), 32'(IRQ_ON));
        repeat (3) tick();
        check("t6_irq_final", 32'(irq), 32'(IRQ_ON));
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
